// File: rtl/tv80_bus_pkg.sv
// Shared definitions for the TV80 external-bus responder: FSM encoding and
// the default data bytes driven onto the CPU data bus.
package tv80_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    localparam logic [7:0] RST38_VECTOR  = 8'hFF;
    localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;

endpackage

// File: rtl/z80_bus_target.sv
// Converts Z80-style memory/IO strobe cycles into single req/ack transactions
// on a synchronous back-end, stretching the CPU with wait_n until completion.
module z80_bus_target
    import tv80_bus_pkg::*;
#(
    parameter logic [7:0] INT_VECTOR = RST38_VECTOR,
    parameter int         TIMEOUT    = 0,
    parameter logic [7:0] TO_DATA    = BUS_IDLE_DATA
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] A,
    input  logic [7:0]  cpu_dout,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    output logic        wait_n,
    output logic [7:0]  di,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_io,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic        bus_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             mem_cyc;
    logic             io_cyc;
    logic             intack;
    logic             active;
    logic             timeout_hit;
    logic             done;

    // Refresh cycles (rfsh_n low) and intack (m1_n low with iorq_n) never reach the back-end.
    assign mem_cyc     = ~mreq_n & rfsh_n & (~rd_n | ~wr_n);
    assign io_cyc      = ~iorq_n & m1_n & (~rd_n | ~wr_n);
    assign intack      = ~iorq_n & ~m1_n;
    assign active      = mem_cyc | io_cyc;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
    assign done        = bus_ack | timeout_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (active) state_next = ST_REQ;
            ST_REQ: begin
                if (done)         state_next = ST_HOLD;
                else if (!active) state_next = ST_ABORT;
            end
            ST_ABORT: if (done) state_next = ST_IDLE;
            ST_HOLD:  if (!active) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Gated by reset_n so an asynchronous reset releases the CPU even mid-strobe.
    always_comb begin
        wait_n = 1'b1;
        if (reset_n && active && (state == ST_IDLE || state == ST_REQ || state == ST_ABORT))
            wait_n = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == ST_IDLE) begin
            cnt <= '0;
        end else if ((state == ST_REQ || state == ST_ABORT) && TIMEOUT != 0 && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            di        <= 8'h00;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_io    <= 1'b0;
            bus_addr  <= 16'h0000;
            bus_wdata <= 8'h00;
            bus_err   <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (active) begin
                        bus_addr  <= A;
                        bus_we    <= ~wr_n;
                        bus_io    <= io_cyc;
                        bus_wdata <= cpu_dout;
                        bus_req   <= 1'b1;
                    end else if (intack) begin
                        di <= INT_VECTOR;
                    end
                end
                ST_REQ: begin
                    // Ack has priority over a coincident watchdog expiry.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) di <= bus_rdata;
                    end else if (timeout_hit) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (!bus_we) di <= TO_DATA;
                    end
                end
                ST_ABORT: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                    end else if (timeout_hit) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_target.sv
// Scenario bench for z80_bus_target: CPU cycles are driven per task, expected
// back-end transactions and read data are queued and checked as they appear.
module tb_z80_bus_target;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic        io;
        logic [7:0]  wdata;
    } txn_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] A;
    logic [7:0]  cpu_dout;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic        wait_n;
    logic [7:0]  di;
    logic        bus_req, bus_we, bus_io;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;
    logic        bus_err;

    int errors = 0;
    int checks = 0;
    int req_hi_cnt = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;
    logic [7:0] exp_di;

    txn_t       exp_q[$];
    logic [7:0] di_q[$];

    z80_bus_target #(.INT_VECTOR(8'hFF), .TIMEOUT(8), .TO_DATA(8'hFF)) dut (
        .clk(clk), .reset_n(reset_n), .A(A), .cpu_dout(cpu_dout),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .m1_n(m1_n), .rfsh_n(rfsh_n), .wait_n(wait_n), .di(di),
        .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_req) req_hi_cnt++;
        if (bus_req && !req_prev) req_rises++;
        req_prev = bus_req;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got hang required finish");
        $fatal(1, "global timeout");
    end

    // kind: 0 mem rd, 1 mem wr, 2 io rd, 3 io wr, 4 mem with rd_n and wr_n both low
    task automatic cpu_start(input int kind, input logic [15:0] addr, input logic [7:0] data);
        txn_t t;
        A        = addr;
        cpu_dout = data;
        mreq_n   = !(kind == 0 || kind == 1 || kind == 4);
        iorq_n   = !(kind == 2 || kind == 3);
        rd_n     = !(kind == 0 || kind == 2 || kind == 4);
        wr_n     = !(kind == 1 || kind == 3 || kind == 4);
        t.addr  = addr;
        t.we    = (kind == 1 || kind == 3 || kind == 4);
        t.io    = (kind == 2 || kind == 3);
        t.wdata = data;
        exp_q.push_back(t);
    endtask

    task automatic cpu_end();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cpu_end();
        bus_ack = 1'b0; bus_rdata = 8'h00; A = 16'h0; cpu_dout = 8'h0;
        #1;
        checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL reset_wait_n got %b need 1", wait_n); end
        checks++; if (di !== 8'h00) begin errors++; $display("FAIL reset_di got %h need 00", di); end
        checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_io !== 1'b0 || bus_err !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl got req=%b we=%b io=%b err=%b need all 0", bus_req, bus_we, bus_io, bus_err);
        end
        checks++; if (bus_addr !== 16'h0 || bus_wdata !== 8'h0) begin
            errors++; $display("FAIL reset_data got addr=%h wdata=%h need 0000/00", bus_addr, bus_wdata);
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_mem_read();
        bit ok;
        txn_t t;
        int hi0;
        @(posedge clk); #1;
        hi0 = req_hi_cnt;
        cpu_start(0, 16'h1234, 8'h00);
        #1;
        checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL rd_wait_same_cycle got %b need 0", wait_n); end
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rd_req_seen got none need bus_req"); end
        t = exp_q.pop_front();
        checks++; if (bus_addr !== t.addr || bus_we !== t.we || bus_io !== t.io) begin
            errors++; $display("FAIL rd_txn got %h/%b/%b need %h/%b/%b", bus_addr, bus_we, bus_io, t.addr, t.we, t.io);
        end
        @(posedge clk); #1;
        checks++; if (wait_n !== 1'b0 || bus_req !== 1'b1) begin
            errors++; $display("FAIL rd_wait_held got wait_n=%b req=%b need 0/1", wait_n, bus_req);
        end
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 8'hA5; di_q.push_back(8'hA5);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        exp_di = di_q.pop_front();
        checks++; if (di !== exp_di) begin errors++; $display("FAIL rd_di got %h need %h", di, exp_di); end
        checks++; if (bus_req !== 1'b0 || wait_n !== 1'b1) begin
            errors++; $display("FAIL rd_release got req=%b wait_n=%b need 0/1", bus_req, wait_n);
        end
        checks++; if (req_hi_cnt - hi0 !== 3) begin errors++; $display("FAIL rd_req_cycles got %0d need 3", req_hi_cnt - hi0); end
        cpu_end();
        @(posedge clk); #1;
    endtask

    task automatic test_io_write();
        bit ok;
        txn_t t;
        int r0;
        @(posedge clk); #1;
        r0 = req_rises;
        cpu_start(3, 16'h00C0, 8'h5A);
        #1;
        checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL wr_wait got %b need 0", wait_n); end
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_req_seen got none need bus_req"); end
        t = exp_q.pop_front();
        checks++; if (bus_addr !== t.addr || bus_we !== t.we || bus_io !== t.io || bus_wdata !== t.wdata) begin
            errors++; $display("FAIL wr_txn got %h/%b/%b/%h need %h/%b/%b/%h",
                bus_addr, bus_we, bus_io, bus_wdata, t.addr, t.we, t.io, t.wdata);
        end
        bus_ack = 1'b1; bus_rdata = 8'hEE;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        checks++; if (bus_req !== 1'b0 || wait_n !== 1'b1) begin
            errors++; $display("FAIL wr_release got req=%b wait_n=%b need 0/1", bus_req, wait_n);
        end
        checks++; if (di !== exp_di) begin errors++; $display("FAIL wr_di_kept got %h need %h", di, exp_di); end
        cpu_end();
        @(posedge clk); #1;
        checks++; if (req_rises - r0 !== 1) begin errors++; $display("FAIL wr_single_req got %0d need 1", req_rises - r0); end
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen;
        int n;
        txn_t t;
        @(posedge clk); #1;
        cpu_start(0, 16'h4000, 8'h00);
        di_q.push_back(8'hFF);
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_req_seen got none need bus_req"); end
        t = exp_q.pop_front();
        checks++; if (bus_addr !== t.addr) begin errors++; $display("FAIL to_addr got %h need %h", bus_addr, t.addr); end
        n = 1; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_err) begin seen = 1'b1; break; end
            if (bus_req) n++;
        end
        exp_di = di_q.pop_front();
        checks++; if (!seen || n !== 8) begin errors++; $display("FAIL to_err_cycle got seen=%b cycles=%0d need 1/8", seen, n); end
        checks++; if (di !== exp_di || wait_n !== 1'b1 || bus_req !== 1'b0) begin
            errors++; $display("FAIL to_complete got di=%h wait_n=%b req=%b need %h/1/0", di, wait_n, bus_req, exp_di);
        end
        bus_ack = 1'b1; bus_rdata = 8'h33;
        @(negedge clk);
        bus_ack = 1'b0;
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse got %b need 0", bus_err); end
        @(negedge clk);
        checks++; if (di !== exp_di || bus_req !== 1'b0) begin
            errors++; $display("FAIL to_late_ack got di=%h req=%b need %h/0", di, bus_req, exp_di);
        end
        cpu_end();
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int          kinds[4]  = '{0, 3, 4, 2};
        logic [15:0] addrs[4]  = '{16'h2000, 16'h0010, 16'h3000, 16'h0020};
        logic [7:0]  wdat[4]   = '{8'h00, 8'h99, 8'h42, 8'h00};
        logic [7:0]  rdat[4]   = '{8'h11, 8'hD1, 8'hD2, 8'h3C};
        int          dly[4]    = '{0, 2, 1, 3};
        bit ok;
        txn_t t;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            cpu_start(kinds[k], addrs[k], wdat[k]);
            #1;
            checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL b2b_wait[%0d] got %b need 0", k, wait_n); end
            wait_req(ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_req[%0d] got none need bus_req", k); end
            t = exp_q.pop_front();
            checks++; if (bus_addr !== t.addr || bus_we !== t.we || bus_io !== t.io || (t.we && bus_wdata !== t.wdata)) begin
                errors++; $display("FAIL b2b_txn[%0d] got %h/%b/%b/%h need %h/%b/%b/%h", k,
                    bus_addr, bus_we, bus_io, bus_wdata, t.addr, t.we, t.io, t.wdata);
            end
            di_q.push_back(t.we ? exp_di : rdat[k]);
            repeat (dly[k]) @(negedge clk);
            bus_ack = 1'b1; bus_rdata = rdat[k];
            @(posedge clk); #1;
            bus_ack = 1'b0;
            exp_di = di_q.pop_front();
            checks++; if (di !== exp_di || wait_n !== 1'b1) begin
                errors++; $display("FAIL b2b_done[%0d] got di=%h wait_n=%b need %h/1", k, di, wait_n, exp_di);
            end
            cpu_end();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_intack();
        @(posedge clk); #1;
        iorq_n = 1'b0; m1_n = 1'b0;
        #1;
        checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL ia_wait got %b need 1", wait_n); end
        @(posedge clk); #1;
        checks++; if (di !== 8'hFF) begin errors++; $display("FAIL ia_di got %h need FF", di); end
        checks++; if (bus_req !== 1'b0 || wait_n !== 1'b1) begin
            errors++; $display("FAIL ia_noreq got req=%b wait_n=%b need 0/1", bus_req, wait_n);
        end
        exp_di = 8'hFF;
        cpu_end();
        @(posedge clk); #1;
    endtask

    task automatic test_refresh();
        @(posedge clk); #1;
        mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus_req !== 1'b0 || wait_n !== 1'b1) begin
                errors++; $display("FAIL rfsh[%0d] got req=%b wait_n=%b need 0/1", i, bus_req, wait_n);
            end
        end
        cpu_end();
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        bit ok;
        txn_t t;
        @(posedge clk); #1;
        cpu_start(0, 16'h5555, 8'h00);
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ab_req_seen got none need bus_req"); end
        t = exp_q.pop_front();
        checks++; if (bus_addr !== t.addr) begin errors++; $display("FAIL ab_addr got %h need %h", bus_addr, t.addr); end
        cpu_end();
        @(negedge clk);
        checks++; if (bus_req !== 1'b1 || wait_n !== 1'b1) begin
            errors++; $display("FAIL ab_held got req=%b wait_n=%b need 1/1", bus_req, wait_n);
        end
        bus_ack = 1'b1; bus_rdata = 8'h77;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        checks++; if (bus_req !== 1'b0 || di !== exp_di || bus_err !== 1'b0) begin
            errors++; $display("FAIL ab_done got req=%b di=%h err=%b need 0/%h/0", bus_req, di, bus_err, exp_di);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        txn_t t;
        @(posedge clk); #1;
        cpu_start(0, 16'h9999, 8'h00);
        wait_req(ok);
        t = exp_q.pop_front();
        checks++; if (!ok || bus_addr !== t.addr) begin
            errors++; $display("FAIL rm_req got ok=%b addr=%h need 1/%h", ok, bus_addr, t.addr);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0 || wait_n !== 1'b1) begin
            errors++; $display("FAIL rm_async got req=%b wait_n=%b need 0/1", bus_req, wait_n);
        end
        checks++; if (bus_addr !== 16'h0 || di !== 8'h00) begin
            errors++; $display("FAIL rm_regs got addr=%h di=%h need 0000/00", bus_addr, di);
        end
        cpu_end();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bus_req !== 1'b0 || wait_n !== 1'b1) begin
            errors++; $display("FAIL rm_after got req=%b wait_n=%b need 0/1", bus_req, wait_n);
        end
    endtask

    initial begin
        exp_di = 8'h00;
        test_reset();
        test_mem_read();
        test_io_write();
        test_timeout();
        test_back_to_back();
        test_intack();
        test_refresh();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/z80_bus_target.md
Name: z80_bus_target

Overview:
- Bus responder for the TV80 CPU wrapper's external Z80-style bus.
- Decodes mreq_n/iorq_n/rd_n/wr_n/m1_n/rfsh_n cycles and converts each one into a single request/acknowledge transaction on a synchronous back-end (ROM/RAM/IO fabric).
- Stretches the CPU cycle with wait_n until the back-end acknowledges, and returns read data on di.
- Answers interrupt-acknowledge cycles locally with a fixed vector.

Parameters:
- INT_VECTOR, 8'hFF, byte returned on an interrupt-acknowledge cycle (RST 38h).
- TIMEOUT, 0, clk cycles to wait for bus_ack before forcing completion; 0 disables the watchdog.
- TO_DATA, 8'hFF, read data returned when a timeout completes a read.

Ports:
- clk, input, 1, system clock (same clock as the CPU).
- reset_n, input, 1, asynchronous active-low reset.
- A, input, 16, CPU address.
- cpu_dout, input, 8, CPU write data.
- mreq_n, input, 1, CPU memory request.
- iorq_n, input, 1, CPU IO request.
- rd_n, input, 1, CPU read strobe.
- wr_n, input, 1, CPU write strobe.
- m1_n, input, 1, CPU opcode-fetch / intack qualifier.
- rfsh_n, input, 1, CPU refresh qualifier.
- wait_n, output, 1, wait request to CPU (combinational).
- di, output, 8, read data to CPU (registered).
- bus_req, output, 1, back-end request (level).
- bus_we, output, 1, 1 = write.
- bus_io, output, 1, 1 = IO space, 0 = memory.
- bus_addr, output, 16, latched address.
- bus_wdata, output, 8, latched write data.
- bus_ack, input, 1, one-cycle completion pulse from back-end.
- bus_rdata, input, 8, read data, valid with bus_ack.
- bus_err, output, 1, one-cycle pulse on watchdog timeout.

Behaviour:
- Reset values: wait_n=1, di=8'h00, bus_req=0, bus_we=0, bus_io=0, bus_addr=0, bus_wdata=0, bus_err=0; state IDLE; timeout counter=0.
- Decode (combinational):
  - mem_cyc = ~mreq_n & rfsh_n & (~rd_n | ~wr_n)
  - io_cyc = ~iorq_n & m1_n & (~rd_n | ~wr_n)
  - intack = ~iorq_n & ~m1_n
  - Refresh (mreq_n=0, rfsh_n=0) is ignored.
  - active = mem_cyc | io_cyc.
- States: IDLE, REQ, HOLD, ABORT.
- IDLE:
  - On active, latch A into bus_addr, ~wr_n into bus_we, io_cyc into bus_io, and cpu_dout into bus_wdata.
  - Assert bus_req next cycle; go to REQ.
  - On intack, load di=INT_VECTOR in the same clk edge; stay in IDLE with no request.
  - rd_n and wr_n both low is treated as a write.
- REQ:
  - bus_req held at 1.
  - On bus_ack: drop bus_req. For a read, load di=bus_rdata. Go to HOLD.
  - If the watchdog expires first (counter == TIMEOUT-1 with TIMEOUT != 0): drop bus_req, pulse bus_err, load di=TO_DATA for a read, go to HOLD.
  - If active deasserts while still in REQ (e.g. reset of CPU only): go to ABORT.
- ABORT: bus_req held until bus_ack or timeout; completion data is discarded, di unchanged; then go to IDLE.
- HOLD: wait for active=0, then go to IDLE. Back-to-back CPU cycles always have a strobe gap, so there is no re-trigger inside one cycle.
- wait_n = ~(active & (state==IDLE | state==REQ | state==ABORT)).
  - wait_n drops in the same cycle the strobe appears.
  - wait_n rises the cycle after bus_ack.
  - Minimum one wait state per back-end cycle.
  - Intack never inserts wait.
- di holds its value until the next read or intack completion.
- bus_ack outside REQ/ABORT is ignored.
- bus_ack and timeout in the same cycle: the ack wins and bus_err stays 0.
- Timeout counter: cleared on entry to REQ; saturates; inactive when TIMEOUT=0.
- Asynchronous reset mid-transaction returns all outputs to reset values immediately; the back-end must tolerate bus_req dropping without ack.

Decomposition:
- Shared package (tv80_bus_pkg):
  - State encoding constants.
  - Decode helper constants RST38_VECTOR=8'hFF and BUS_IDLE_DATA=8'hFF.
- Single flat module; no sub-module is warranted. The watchdog counter is inline.

Test Plan:
- Memory read: A=16'h1234, mreq_n=0, rd_n=0, bus_ack after 3 clk with bus_rdata=8'hA5 -> bus_req high 3 clk, bus_addr=1234, bus_io=0, wait_n low until the cycle after ack, di=8'hA5.
- IO write: A=16'h00C0, iorq_n=0, wr_n=0, cpu_dout=8'h5A -> bus_we=1, bus_io=1, bus_wdata=8'h5A; single req/ack; di unchanged.
- Intack: m1_n=0, iorq_n=0 -> wait_n stays 1, bus_req stays 0, di=8'hFF next edge.
- Refresh: mreq_n=0, rfsh_n=0, rd_n=1 -> no bus_req, wait_n=1.
- Timeout: TIMEOUT=8, no ack on a read -> bus_err one pulse at cycle 8, di=8'hFF, wait_n released; a late ack is ignored.
- Reset and abort:
  - reset_n low during REQ -> bus_req=0 and wait_n=1 asynchronously.
  - Strobe removed in REQ -> ABORT; ack data 8'h77 is not loaded into di.
